shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift stage feeding the integer ALU's single-position shifter.
//  Accepts an operand, shift op and shift amount over a valid/ready handshake.
//  Applies one single-bit shift per clock, using the shift_step sub-module, until
//  the amount is exhausted.
//  Presents the result on a valid/ready output toward the ALU result mux.
// PARAMETERS
//  WIDTH  4  operand/result width in bits (signed two's complement)
//  AMT_W  3  shift-amount port width; must satisfy 2**AMT_W > WIDTH
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       reset, asynchronous assert, active-low
//  in_valid   in   1       operand/op/amt valid
//  in_ready   out  1       stage can accept; equals (state==IDLE)
//  in_data    in   WIDTH   operand to shift
//  in_op      in   2       00 ASR, 01 LSR, 10 SHL, 11 pass-through
//  in_amt     in   AMT_W   number of positions to shift
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  out_data   out  WIDTH   shifted result
//  busy       out  1       high in SHIFT or DONE
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset (rst_n=0):
//   - state=IDLE; out_valid=0; out_data=0; busy=0; internal count=0.
//   - in_ready=1 immediately after reset deasserts.
//  FSM states: IDLE, SHIFT, DONE.
//   - IDLE: in_ready=1. On in_valid&in_ready, latch data/op and count=min(in_amt,WIDTH).
//     Go to DONE if count==0 or op==11, else go to SHIFT.
//   - SHIFT: each clock, data<=shift_step(data,op) and count<=count-1.
//     Go to DONE on the edge where count==1.
//   - DONE: out_valid=1; out_data is held stable. On out_valid&out_ready, go to IDLE.
//  Latency: out_valid rises N edges after the accepting edge, N=min(amt,WIDTH).
//   - N=0: out_valid rises on the accepting edge itself.
//   - Throughput: one operation per N+2 clocks minimum.
//  Arithmetic rules:
//   - ASR shifts in the sign bit (MSB replicated).
//   - LSR shifts in 0 at the MSB.
//   - SHL shifts in 0 at the LSB; MSB is discarded, no overflow flag.
//  Boundary cases:
//   - amt > WIDTH is clamped to WIDTH. ASR then yields all sign bits; LSR/SHL yield 0.
//   - in_valid while busy is ignored (in_ready=0); the upstream must hold its data.
//   - out_ready=0 in DONE: hold indefinitely with no change to out_data.
//   - out_ready high before DONE has no effect.
//   - Reset mid-SHIFT or mid-DONE: operation discarded, all regs to reset values.
//   - A new input is not accepted in the same cycle as the DONE handoff; IDLE is entered first.
// STRUCTURE
//  Include file shift_defs.vh holds the op encodings:
//   OP_ASR=2'b00, OP_LSR=2'b01, OP_SHL=2'b10, OP_PASS=2'b11.
//   It also holds the state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
//  Sub-module shift_step: combinational one-position shift (WIDTH param, data+op in,
//   data out). Instantiated once inside the sequencer.
//  Sequencer: FSM, count register, data register, handshake logic.
// TESTING
//  1. ASR 1101, amt=1 -> out 1110, out_valid 1 edge after accept.
//  2. ASR 0101, amt=2 -> out 0001 after 2 edges; LSR 1100, amt=2 -> 0011.
//  3. SHL 0011, amt=1 -> 0110; op=11 1010, amt=3 -> 1010 with zero latency.
//  4. ASR 1000, amt=7 (clamped to 4) -> 1111 after 4 edges; LSR same -> 0000.
//  5. Backpressure: out_ready=0 for 3 clocks in DONE -> out_data stable, in_ready=0.
//     A pulsed in_valid during this time is ignored.
//  6. rst_n low mid-SHIFT (ASR 0111, amt=3, after 1 edge) ->
//     out_valid=0, out_data=0, in_ready=1 once reset is released.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings and default sizes for the multi-cycle shift stage.
package shift_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 4;  // operand/result width
  localparam int unsigned DEF_AMT_W = 3;  // shift-amount width, 2**DEF_AMT_W > DEF_WIDTH
  localparam int unsigned OP_W      = 2;  // shift-op field width

  typedef enum logic [OP_W-1:0] {
    OP_ASR  = 2'b00,
    OP_LSR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_step.sv
// Combinational single-position shifter.
//   data_i : operand (two's complement)
//   op_i   : ASR / LSR / SHL / PASS
//   data_o : operand moved by one bit position (unchanged for PASS)
module shift_sequencer_step
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_ASR:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      OP_LSR:  data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SHL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      default: data_o = data_i;
    endcase
  end

endmodule : shift_sequencer_step

// File: rtl/shift_sequencer.sv
// Multi-cycle shift stage: accepts operand/op/amount, shifts one bit per clock,
// and holds the result on a valid/ready output until taken.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake (in_ready high only in IDLE)
//   in_data/in_op/in_amt: operand, op (00 ASR, 01 LSR, 10 SHL, 11 PASS), amount
//   out_valid/out_ready : output handshake (out_valid high only in DONE)
//   out_data            : result register
//   busy                : high in SHIFT or DONE
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [OP_W-1:0]  in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] count_q, count_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] step_data;
  logic [AMT_W-1:0] amt_clamped;
  op_e              in_op_e;

  assign in_op_e = op_e'(in_op);

  // Amounts past the operand width all produce the same result as WIDTH.
  assign amt_clamped = (in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : in_amt;

  shift_sequencer_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .data_o (step_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      op_q    <= OP_ASR;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          op_d    = in_op_e;
          count_d = amt_clamped;
          // Zero-length and pass-through ops finish on the accepting edge.
          if ((amt_clamped == '0) || (in_op_e == OP_PASS)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d  = step_data;
        count_d = count_q - AMT_W'(1);
        if (count_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE first means no accept can overlap the handoff.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from the state and data flops.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = data_q;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      SHIFT:   busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

endmodule : shift_sequencer
